// File: rtl/minmax_scan_display.sv
// Captures min/max of two unsigned operands and scans them as hex digits
// across common-enable 7-segment displays with prescaled, blanked slots.
module minmax_scan_display #(
   parameter int unsigned W     = 8,
   parameter int unsigned DIV   = 50000,
   parameter int unsigned BLANK = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [W-1:0]           a,
   input  logic [W-1:0]           b,
   output logic [6:0]             d7seg,
   output logic [2*(W/4)-1:0]     dig,
   output logic                   loaded
);

   localparam int unsigned ND   = W / 4;
   localparam int unsigned NDIG = 2 * ND;
   localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IW   = $clog2(NDIG);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [W-1:0]      mn, mx;
   logic [2*W-1:0]    disp;
   logic [3:0]        nib;
   logic              lit;
   logic [NDIG-1:0]   dig_nx;
   logic [6:0]        seg_nx;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b0111111;
         4'h1: hex7 = 7'b0000110;
         4'h2: hex7 = 7'b1011011;
         4'h3: hex7 = 7'b1001111;
         4'h4: hex7 = 7'b1100110;
         4'h5: hex7 = 7'b1101101;
         4'h6: hex7 = 7'b1111101;
         4'h7: hex7 = 7'b0000111;
         4'h8: hex7 = 7'b1111111;
         4'h9: hex7 = 7'b1101111;
         4'hA: hex7 = 7'b1110111;
         4'hB: hex7 = 7'b1111100;
         4'hC: hex7 = 7'b0111001;
         4'hD: hex7 = 7'b1011110;
         4'hE: hex7 = 7'b1111001;
         default: hex7 = 7'b1110001;
      endcase
   endfunction

   // mx sits above mn so digit idx maps straight onto nibble idx of disp
   always_comb begin
      disp   = {mx, mn};
      nib    = disp[{idx, 2'b00} +: 4];
      lit    = loaded && (32'(cnt) >= BLANK);
      dig_nx = '0;
      seg_nx = '0;
      if (lit) begin
         dig_nx = NDIG'(1) << idx;
         seg_nx = hex7(nib);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         idx    <= '0;
         mn     <= '0;
         mx     <= '0;
         loaded <= 1'b0;
         dig    <= '0;
         d7seg  <= '0;
      end else begin
         if (load) begin
            mn     <= (a < b) ? a : b;
            mx     <= (a < b) ? b : a;
            loaded <= 1'b1;
         end
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         dig   <= dig_nx;
         d7seg <= seg_nx;
      end
   end

endmodule

// File: tb/tb_minmax_scan_display.sv
// Scoreboard bench for minmax_scan_display (W=8, DIV=4, BLANK=1): expected
// per-edge outputs are queued by the stimulus and checked by a negedge monitor.
module tb_minmax_scan_display;

   localparam int NONE = 1 << 30;

   localparam logic [6:0] S0 = 7'b0111111;
   localparam logic [6:0] S1 = 7'b0000110;
   localparam logic [6:0] S3 = 7'b1001111;
   localparam logic [6:0] S5 = 7'b1101101;
   localparam logic [6:0] S7 = 7'b0000111;
   localparam logic [6:0] SA = 7'b1110111;
   localparam logic [6:0] SC = 7'b0111001;
   localparam logic [6:0] SF = 7'b1110001;

   typedef struct {
      int         en;
      logic [3:0] dig;
      logic [6:0] seg;
      logic       ld;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [7:0] a, b;
   logic [6:0] d7seg;
   logic [3:0] dig;
   logic       loaded;

   int   checks = 0;
   int   errors = 0;
   int   ecnt = 0;
   exp_t q[$];
   exp_t me;
   bit   phase2 = 1'b0;

   // scan-timing statistics over one observation window
   int         lit_n = 0, blank_n = 0, wraps = 0, runs_done = 0;
   int         run = 0, run_bad = 0, onehot_bad = 0, adj_bad = 0;
   logic [3:0] prev_dig = '0, last_lit = '0;

   minmax_scan_display #(.W(8), .DIV(4), .BLANK(1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .a      (a),
      .b      (b),
      .d7seg  (d7seg),
      .dig    (dig),
      .loaded (loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, expv);
      end
   endtask

   // expected output after edge k reflects state s=k-1 (cnt=s%4, idx=(s/4)%4)
   task automatic push_range(input int from, input int to, input int first_ld, input int set_ld,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] segs [4];
      segs = '{s0, s1, s2, s3};
      for (int k = from; k <= to; k++) begin
         exp_t e;
         int   s;
         s    = k - 1;
         e.en = k;
         if (set_ld <= s && (s % 4) != 0) begin
            e.dig = 4'b0001 << ((s / 4) % 4);
            e.seg = segs[(s / 4) % 4];
         end else begin
            e.dig = '0;
            e.seg = '0;
         end
         e.ld = (first_ld <= k);
         q.push_back(e);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_load(input logic [7:0] va, input logic [7:0] vb);
      load = 1'b1;
      a    = va;
      b    = vb;
      @(posedge clk);
      #2;
      load = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (q.size() > 0 && q[0].en <= ecnt) begin
            me = q.pop_front();
            checks++;
            if (me.en < ecnt) begin
               errors++;
               $display("FAIL missed edge %0d: sampled at edge %0d", me.en, ecnt);
            end else if (dig !== me.dig || d7seg !== me.seg || loaded !== me.ld) begin
               errors++;
               $display("FAIL edge %0d: got dig=%b seg=%b loaded=%b expected dig=%b seg=%b loaded=%b",
                        ecnt, dig, d7seg, loaded, me.dig, me.seg, me.ld);
            end
         end
         if (!phase2 && ecnt >= 22 && ecnt <= 69) begin
            if ((dig & (dig - 4'd1)) != 4'd0) onehot_bad++;
            if (dig != 4'd0) begin
               lit_n++;
               if (prev_dig != 4'd0 && prev_dig != dig) adj_bad++;
               run = (dig == prev_dig) ? run + 1 : 1;
               if (dig == 4'b0001 && last_lit == 4'b1000) wraps++;
               last_lit = dig;
            end else begin
               blank_n++;
               if (run != 0) begin
                  runs_done++;
                  if (run != 3) run_bad++;
               end
               run = 0;
            end
            prev_dig = dig;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      load  = 1'b0;
      a     = '0;
      b     = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("reset dig", 32'(dig), 32'd0);
      chk("reset d7seg", 32'(d7seg), 32'd0);
      chk("reset loaded", 32'(loaded), 32'd0);
      push_range(1, 20, NONE, NONE, S0, S0, S0, S0);
      #4 rst_n = 1'b1;
      wait_edges(20);

      // 0x3C/0x15 -> mn=15, mx=3C: digits 5,1,C,3
      push_range(21, 75, 21, 21, S5, S1, SC, S3);
      do_load(8'h3C, 8'h15);
      wait_edges(53);

      // load while state cnt=2 of slot 2: mn=0F, mx=F0 -> digits F,0,0,F
      push_range(76, 101, 21, 75, SF, S0, S0, SF);
      do_load(8'hF0, 8'h0F);
      wait_edges(25);

      push_range(102, 126, 21, 101, S7, SA, S7, SA);
      do_load(8'hA7, 8'hA7);
      wait_edges(25);

      #5;
      chk("queue drained before reset", 32'(q.size()), 32'd0);
      chk("dig before async reset", 32'(dig), 32'b1000);
      rst_n = 1'b0;
      #1;
      chk("async reset dig", 32'(dig), 32'd0);
      chk("async reset d7seg", 32'(d7seg), 32'd0);
      chk("async reset loaded", 32'(loaded), 32'd0);
      phase2 = 1'b1;
      push_range(1, 20, NONE, NONE, S0, S0, S0, S0);
      repeat (2) @(posedge clk);
      #7 rst_n = 1'b1;
      wait_edges(20);

      push_range(21, 60, 21, 21, S5, S1, SC, S3);
      do_load(8'h3C, 8'h15);
      wait_edges(40);
      #5;

      chk("queue drained at end", 32'(q.size()), 32'd0);
      chk("lit cycles in 3 periods", 32'(lit_n), 32'd36);
      chk("blank cycles in 3 periods", 32'(blank_n), 32'd12);
      chk("idx wraps in 3 periods", 32'(wraps), 32'd3);
      chk("completed slots", 32'(runs_done), 32'd12);
      chk("slots not 3 lit cycles", 32'(run_bad), 32'd0);
      chk("multi-bit dig cycles", 32'(onehot_bad), 32'd0);
      chk("adjacent enables without blank", 32'(adj_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
